mux_arb: RTL and testbench
==========================

MUX_ARB -- requirements
Module: mux_arb

Interface
REQ-001 Parameter DATAW, default 66: flit width; flit type in bits [DATAW-1:DATAW-2], payload below.
REQ-002 Parameter TIMEOUT, default 32: idle cycles tolerated inside a locked packet before forced release.
REQ-003 Port clk  input  1: single clock; all state updates on rising edge.
REQ-004 Port rst_  input  1: reset, asynchronous, active-low.
REQ-005 Port idata_0 / idata_1  input  DATAW: flit presented by requester 0 / 1 (type field only is inspected).
REQ-006 Port ivalid_0 / ivalid_1  input  1: flit on idata_n is valid.
REQ-007 Port ordy  input  1: downstream accepts the muxed flit this cycle.
REQ-008 Port sel  output  2: one-hot mux select (bit n = port n); 2'b00 = none.
REQ-009 Port iready_0 / iready_1  output  1: flit on port n consumed this cycle.
REQ-010 Port busy  output  1: a packet is locked through the mux.
REQ-011 Port err  output  1: one-cycle protocol-error / timeout pulse.

Function
REQ-012 Flit type encoding TYPE_NONE/HEAD/DATA/TAIL SHALL come from the shared constants package; arbiter decodes only these.
REQ-013 FSM states SHALL be IDLE, LOCK0, LOCK1; busy = (state != IDLE); sel = 2'b01 in LOCK0, 2'b10 in LOCK1, 2'b00 in IDLE, all registered.
REQ-014 In IDLE a request on port n = ivalid_n & type HEAD; non-head valid flits in IDLE are ignored and SHALL pulse err.
REQ-015 In IDLE with one request, next state = LOCKn; grant latency exactly one cycle from request to sel.
REQ-016 In IDLE with both requests, port indicated by round-robin pointer wins; pointer resets to port 0.
REQ-017 iready_n = ordy & ivalid_n & (state == LOCKn), combinational; iready of the non-granted port SHALL be 0.
REQ-018 In LOCKn, consumption (iready_n) of a TAIL flit SHALL return FSM to IDLE next cycle and set pointer to the other port.
REQ-019 TAIL with ordy low SHALL hold LOCKn until accepted; no flit is dropped or duplicated.
REQ-020 In LOCKn, a valid HEAD on port n SHALL pulse err; flit is still forwarded, lock kept.
REQ-021 Idle counter SHALL count cycles in LOCKn without an accepted flit; reset to 0 on each acceptance and on entry to LOCKn.
REQ-022 Counter reaching TIMEOUT SHALL force IDLE, pulse err one cycle, advance pointer; counter saturates, never wraps.
REQ-023 Request on the non-locked port during LOCKn SHALL wait; it is arbitrated in the IDLE cycle following release.
REQ-024 IDLE lasts at least one cycle between packets (release and new grant never same edge).

Reset
REQ-025 On rst_ low, immediately: state IDLE, sel 2'b00, busy 0, err 0, pointer port 0, idle counter 0; iready_n 0.
REQ-026 Reset asserted mid-packet SHALL abandon the packet; no state retained after release.

Structure
REQ-027 Flit-type codes, TYPEW=2 and default DATAW SHALL live in the shared constants package used by mux and router.
REQ-028 Round-robin pointer plus priority select SHALL be sub-module rr_pick2 (req[1:0], ptr -> one-hot gnt); FSM and counter stay in mux_arb.

Verification
REQ-029 Port 1 only: HEAD, 20 DATA, TAIL, ordy=1 -> sel=2'b10 one cycle after HEAD, iready_1 high 22 cycles, busy drops after TAIL, err never set.
REQ-030 Both HEAD same cycle after reset -> port 0 granted first; after its TAIL, port 1 granted after one IDLE cycle.
REQ-031 ordy toggled 1/0 during port 0 packet -> iready_0 mirrors ordy; TAIL held with ordy=0 keeps LOCK0 until accepted.
REQ-032 Port 0 locked, ivalid_0 low 32 cycles -> IDLE on 32nd, err one-cycle pulse, pointer = port 1.
REQ-033 rst_ low during LOCK1 mid-packet -> sel=0, busy=0 asynchronously; DATA flit on port 1 after release ignored with err pulse.
REQ-034 DATA flit on port 0 in IDLE -> no grant, err pulses once per such cycle.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared flit/arbiter constants: flit-type codes, default flit width and
// the arbiter state encoding used by the mux and the router.
package mux_arb_pkg;

    localparam int TYPEW     = 2;
    localparam int DATAW_DEF = 66;

    typedef enum logic [TYPEW-1:0] {
        TYPE_NONE = 2'b00,
        TYPE_HEAD = 2'b01,
        TYPE_DATA = 2'b10,
        TYPE_TAIL = 2'b11
    } flit_type_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOCK0 = 2'b01,
        LOCK1 = 2'b10
    } state_e;

    function automatic flit_type_e flit_type(input logic [TYPEW-1:0] raw);
        return flit_type_e'(raw);
    endfunction

endpackage

// File: rtl/mux_arb_rr_pick2.sv
// Two-way round-robin picker: holds the priority pointer and turns a
// two-bit request vector into a one-hot grant.
module rr_pick2 (
    input  logic       clk,
    input  logic       rst_,
    input  logic [1:0] req,
    input  logic       upd,
    input  logic       upd_ptr,
    output logic [1:0] gnt
);

    logic ptr_q;
    logic ptr_d;

    // pointer next value: only moves when the owner releases the mux
    always_comb begin
        ptr_d = ptr_q;
        if (upd) begin
            ptr_d = upd_ptr;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // pointer register, port 0 preferred out of reset
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // priority select; a tie goes to the port the pointer names
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mux_arb.sv
// Packet-locking 2:1 flit mux arbiter: a HEAD wins the mux, the packet
// stays locked until its TAIL is consumed or the idle timeout expires.
module mux_arb
    import mux_arb_pkg::*;
#(
    parameter int DATAW   = DATAW_DEF,
    parameter int TIMEOUT = 32
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic [DATAW-1:0] idata_0,
    input  logic [DATAW-1:0] idata_1,
    input  logic             ivalid_0,
    input  logic             ivalid_1,
    input  logic             ordy,
    output logic [1:0]       sel,
    output logic             iready_0,
    output logic             iready_1,
    output logic             busy,
    output logic             err
);

    localparam int CNTW = $clog2(TIMEOUT + 1);
    localparam logic [CNTW-1:0] CNT_MAX = CNTW'(TIMEOUT);

    state_e            state_q, state_d;
    logic [CNTW-1:0]   cnt_q, cnt_d, cnt_inc_s;
    logic              head_seen_q, head_seen_d;
    logic [1:0]        sel_q, sel_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;

    flit_type_e        type_0_s, type_1_s;
    logic [1:0]        req_s, gnt_s;
    logic              bad_idle_s;
    logic              lk_valid_s, lk_acc_s;
    flit_type_e        lk_type_s;
    logic              ptr_upd_s, ptr_nxt_s;
    logic              unused_payload_s;

    assign type_0_s = flit_type(idata_0[DATAW-1 -: TYPEW]);
    assign type_1_s = flit_type(idata_1[DATAW-1 -: TYPEW]);
    assign unused_payload_s = ^{idata_0[DATAW-TYPEW-1:0], idata_1[DATAW-TYPEW-1:0]};

    assign iready_0 = ordy & ivalid_0 & (state_q == LOCK0);
    assign iready_1 = ordy & ivalid_1 & (state_q == LOCK1);

    assign sel  = sel_q;
    assign busy = busy_q;
    assign err  = err_q;

    assign req_s[0]   = ivalid_0 & (type_0_s == TYPE_HEAD);
    assign req_s[1]   = ivalid_1 & (type_1_s == TYPE_HEAD);
    assign bad_idle_s = (ivalid_0 & (type_0_s != TYPE_HEAD)) |
                        (ivalid_1 & (type_1_s != TYPE_HEAD));
    assign cnt_inc_s  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNTW'(1);

    rr_pick2 u_pick (
        .clk     (clk),
        .rst_    (rst_),
        .req     (req_s),
        .upd     (ptr_upd_s),
        .upd_ptr (ptr_nxt_s),
        .gnt     (gnt_s)
    );

    // view of the port that currently owns the mux
    always_comb begin
        lk_valid_s = 1'b0;
        lk_type_s  = TYPE_NONE;
        lk_acc_s   = 1'b0;
        case (state_q)
            LOCK0: begin
                lk_valid_s = ivalid_0;
                lk_type_s  = type_0_s;
                lk_acc_s   = iready_0;
            end
            LOCK1: begin
                lk_valid_s = ivalid_1;
                lk_type_s  = type_1_s;
                lk_acc_s   = iready_1;
            end
            default: begin
                lk_valid_s = 1'b0;
                lk_type_s  = TYPE_NONE;
                lk_acc_s   = 1'b0;
            end
        endcase
    end

    // next state, idle counter, error pulse and pointer update
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        head_seen_d = head_seen_q;
        err_d       = 1'b0;
        ptr_upd_s   = 1'b0;
        ptr_nxt_s   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d       = '0;
                head_seen_d = 1'b0;
                err_d       = bad_idle_s;
                if (gnt_s == 2'b01) begin
                    state_d = LOCK0;
                end else if (gnt_s == 2'b10) begin
                    state_d = LOCK1;
                end else begin
                    state_d = IDLE;
                end
            end
            LOCK0, LOCK1: begin
                // the opening HEAD is the first flit consumed; any later HEAD is a protocol error
                if (lk_valid_s && (lk_type_s == TYPE_HEAD) && head_seen_q) begin
                    err_d = 1'b1;
                end else begin
                    err_d = 1'b0;
                end
                if (lk_acc_s) begin
                    cnt_d       = '0;
                    head_seen_d = 1'b1;
                    if (lk_type_s == TYPE_TAIL) begin
                        state_d   = IDLE;
                        ptr_upd_s = 1'b1;
                        ptr_nxt_s = (state_q == LOCK0);
                    end else begin
                        state_d = state_q;
                    end
                end else begin
                    cnt_d = cnt_inc_s;
                    if (cnt_inc_s == CNT_MAX) begin
                        state_d   = IDLE;
                        err_d     = 1'b1;
                        ptr_upd_s = 1'b1;
                        ptr_nxt_s = (state_q == LOCK0);
                    end else begin
                        state_d = state_q;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                cnt_d       = '0;
                head_seen_d = 1'b0;
            end
        endcase
    end

    // registered outputs follow the next state so they line up with state_q
    always_comb begin
        sel_d  = 2'b00;
        busy_d = (state_d != IDLE);
        case (state_d)
            LOCK0:   sel_d = 2'b01;
            LOCK1:   sel_d = 2'b10;
            default: sel_d = 2'b00;
        endcase
    end

    // state and output registers
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            head_seen_q <= 1'b0;
            sel_q       <= 2'b00;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            head_seen_q <= head_seen_d;
            sel_q       <= sel_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_mux_arb.sv
// Scoreboard bench for mux_arb: expected consumed flits are queued per
// scenario and a negedge monitor pops them as the DUT raises iready.
module tb_mux_arb;
    import mux_arb_pkg::*;

    localparam int DW = 66;

    typedef struct {
        int            port;
        logic [DW-1:0] flit;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_;
    logic [DW-1:0] idata_0, idata_1;
    logic          ivalid_0, ivalid_1, ordy;
    logic [1:0]    sel;
    logic          iready_0, iready_1, busy, err;

    exp_t exp_q[$];
    int   checks  = 0;
    int   errors  = 0;
    int   err_cnt = 0;
    int   ir1_cnt = 0;
    logic hold_phase;

    always #5 clk = ~clk;

    mux_arb #(.DATAW(DW), .TIMEOUT(32)) dut (
        .clk      (clk),
        .rst_     (rst_),
        .idata_0  (idata_0),
        .idata_1  (idata_1),
        .ivalid_0 (ivalid_0),
        .ivalid_1 (ivalid_1),
        .ordy     (ordy),
        .sel      (sel),
        .iready_0 (iready_0),
        .iready_1 (iready_1),
        .busy     (busy),
        .err      (err)
    );

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    function automatic void push(input int port, input logic [1:0] t, input logic [63:0] p);
        exp_t e;
        e.port = port;
        e.flit = {t, p};
        exp_q.push_back(e);
    endfunction

    // present one flit and hold it until consumed; waited = negedges seen incl. the accepting one
    task automatic drive(input int port, input logic [1:0] t, input logic [63:0] p, output int waited);
        int n;
        n = 0;
        if (port == 0) begin idata_0 = {t, p}; ivalid_0 = 1'b1; end
        else begin idata_1 = {t, p}; ivalid_1 = 1'b1; end
        forever begin
            @(negedge clk);
            n++;
            if ((port == 0 && iready_0) || (port == 1 && iready_1)) break;
            if (n >= 200) begin
                checks++;
                errors++;
                $display("FAIL drive_timeout: port %0d no iready after %0d cycles, required acceptance", port, n);
                break;
            end
        end
        @(posedge clk);
        #1;
        if (port == 0) ivalid_0 = 1'b0;
        else ivalid_1 = 1'b0;
        waited = n;
    endtask

    task automatic do_reset();
        ivalid_0 = 1'b0;
        ivalid_1 = 1'b0;
        ordy     = 1'b1;
        rst_     = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_ = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w, wa, wb, bad, e0, r0;
        rst_       = 1'b0;
        ordy       = 1'b1;
        hold_phase = 1'b0;
        idata_0    = {TYPE_HEAD, 64'h0};
        idata_1    = {TYPE_HEAD, 64'h0};
        ivalid_0   = 1'b1;
        ivalid_1   = 1'b1;

        fork
            begin : monitor
                exp_t e;
                forever begin
                    @(negedge clk);
                    if (err) err_cnt++;
                    if (iready_1) ir1_cnt++;
                    if (iready_0 || iready_1) begin
                        chk_i("iready_onehot", int'(iready_0 & iready_1), 0);
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_consume: iready_0 %0b iready_1 %0b, required none", iready_0, iready_1);
                        end else begin
                            e = exp_q.pop_front();
                            chk_i("consume_port", iready_1 ? 1 : 0, e.port);
                            chk("consume_flit", iready_1 ? idata_1 : idata_0, e.flit);
                        end
                    end
                end
            end
        join_none

        // reset state with both requesters shouting HEAD and ordy high
        repeat (2) @(negedge clk);
        chk_i("rst_sel", int'(sel), 0);
        chk_i("rst_busy", int'(busy), 0);
        chk_i("rst_err", int'(err), 0);
        chk_i("rst_iready", int'({iready_1, iready_0}), 0);
        do_reset();

        // port 1 alone: HEAD, 20 DATA, TAIL
        e0 = err_cnt;
        r0 = ir1_cnt;
        for (int i = 0; i < 22; i++)
            push(1, (i == 0) ? TYPE_HEAD : ((i == 21) ? TYPE_TAIL : TYPE_DATA), 64'(i));
        drive(1, TYPE_HEAD, 64'd0, w);
        chk_i("p1_grant_latency", w, 2);
        chk_i("p1_sel_locked", int'(sel), 2);
        chk_i("p1_busy_locked", int'(busy), 1);
        bad = 0;
        for (int i = 1; i < 21; i++) begin
            drive(1, TYPE_DATA, 64'(i), w);
            if (w != 1) bad++;
        end
        chk_i("p1_data_stream_stalls", bad, 0);
        drive(1, TYPE_TAIL, 64'd21, w);
        chk_i("p1_busy_after_tail", int'(busy), 0);
        chk_i("p1_sel_after_tail", int'(sel), 0);
        chk_i("p1_iready_cycles", ir1_cnt - r0, 22);
        chk_i("p1_err_count", err_cnt - e0, 0);

        // both HEADs in the same cycle after reset: port 0 first, port 1 after one IDLE cycle
        do_reset();
        e0 = err_cnt;
        push(0, TYPE_HEAD, 64'h100); push(0, TYPE_DATA, 64'h101);
        push(0, TYPE_DATA, 64'h102); push(0, TYPE_TAIL, 64'h103);
        push(1, TYPE_HEAD, 64'h200); push(1, TYPE_DATA, 64'h201);
        push(1, TYPE_TAIL, 64'h202);
        fork
            begin
                drive(0, TYPE_HEAD, 64'h100, wa);
                chk_i("both_p0_grant_latency", wa, 2);
                drive(0, TYPE_DATA, 64'h101, wa);
                drive(0, TYPE_DATA, 64'h102, wa);
                drive(0, TYPE_TAIL, 64'h103, wa);
            end
            begin
                drive(1, TYPE_HEAD, 64'h200, wb);
                chk_i("both_p1_wait", wb, 7);
                chk_i("both_p1_sel", int'(sel), 2);
                drive(1, TYPE_DATA, 64'h201, wb);
                drive(1, TYPE_TAIL, 64'h202, wb);
            end
        join
        chk_i("both_err_count", err_cnt - e0, 0);

        // ordy toggling during a port 0 packet, then TAIL held with ordy low
        do_reset();
        push(0, TYPE_HEAD, 64'h300); push(0, TYPE_DATA, 64'h301);
        push(0, TYPE_DATA, 64'h302); push(0, TYPE_DATA, 64'h303);
        push(0, TYPE_TAIL, 64'h304);
        hold_phase = 1'b0;
        fork
            begin
                drive(0, TYPE_HEAD, 64'h300, wa);
                drive(0, TYPE_DATA, 64'h301, wa);
                drive(0, TYPE_DATA, 64'h302, wa);
                drive(0, TYPE_DATA, 64'h303, wa);
                hold_phase = 1'b1;
            end
            begin
                for (int n = 0; n < 200 && !hold_phase; n++) begin
                    @(negedge clk);
                    if (sel == 2'b01 && ivalid_0)
                        chk_i("iready_mirrors_ordy", int'(iready_0), int'(ordy));
                    @(posedge clk);
                    #1 ordy = ~ordy;
                end
            end
        join
        ordy     = 1'b0;
        idata_0  = {TYPE_TAIL, 64'h304};
        ivalid_0 = 1'b1;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (iready_0 || sel != 2'b01 || !busy) bad++;
        end
        chk_i("tail_held_lock0", bad, 0);
        @(posedge clk);
        #1 ordy = 1'b1;
        @(negedge clk);
        chk_i("tail_accepted", int'(iready_0), 1);
        @(posedge clk);
        #1 ivalid_0 = 1'b0;
        chk_i("tail_release_busy", int'(busy), 0);

        // port 0 locked then silent: timeout after 32 idle cycles, pointer moves to port 1
        do_reset();
        e0 = err_cnt;
        push(0, TYPE_HEAD, 64'h400);
        drive(0, TYPE_HEAD, 64'h400, w);
        bad = 0;
        repeat (31) begin
            @(negedge clk);
            if (!busy || err) bad++;
        end
        chk_i("to_lock_held", bad, 0);
        @(negedge clk);
        chk_i("to_busy_before", int'(busy), 1);
        @(negedge clk);
        chk_i("to_busy_released", int'(busy), 0);
        chk_i("to_sel_released", int'(sel), 0);
        chk_i("to_err_pulse", int'(err), 1);
        @(negedge clk);
        chk_i("to_err_one_cycle", int'(err), 0);
        @(posedge clk);
        #1;
        push(1, TYPE_HEAD, 64'h410); push(1, TYPE_TAIL, 64'h411);
        push(0, TYPE_HEAD, 64'h420); push(0, TYPE_TAIL, 64'h421);
        fork
            begin
                drive(0, TYPE_HEAD, 64'h420, wa);
                chk_i("to_p0_waits", wa, 5);
                drive(0, TYPE_TAIL, 64'h421, wa);
            end
            begin
                drive(1, TYPE_HEAD, 64'h410, wb);
                chk_i("to_p1_wins", wb, 2);
                drive(1, TYPE_TAIL, 64'h411, wb);
            end
        join
        chk_i("to_err_count", err_cnt - e0, 1);

        // reset in the middle of a port 1 packet
        do_reset();
        push(1, TYPE_HEAD, 64'h500); push(1, TYPE_DATA, 64'h501);
        push(1, TYPE_DATA, 64'h502);
        drive(1, TYPE_HEAD, 64'h500, w);
        drive(1, TYPE_DATA, 64'h501, w);
        drive(1, TYPE_DATA, 64'h502, w);
        idata_1  = {TYPE_DATA, 64'h503};
        ivalid_1 = 1'b1;
        #2 rst_  = 1'b0;
        #1;
        chk_i("midrst_sel", int'(sel), 0);
        chk_i("midrst_busy", int'(busy), 0);
        chk_i("midrst_iready", int'(iready_1), 0);
        e0 = err_cnt;
        @(posedge clk);
        #3 rst_ = 1'b1;
        @(posedge clk);
        #1 ivalid_1 = 1'b0;
        @(negedge clk);
        chk_i("midrst_data_err", int'(err), 1);
        chk_i("midrst_no_grant", int'(busy), 0);
        @(negedge clk);
        chk_i("midrst_err_count", err_cnt - e0, 1);

        // DATA on port 0 while IDLE for three cycles
        @(posedge clk);
        #1;
        e0 = err_cnt;
        idata_0  = {TYPE_DATA, 64'h600};
        ivalid_0 = 1'b1;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (sel != 2'b00 || busy || iready_0) bad++;
        end
        chk_i("idle_data_no_grant", bad, 0);
        @(posedge clk);
        #1 ivalid_0 = 1'b0;
        repeat (2) @(negedge clk);
        chk_i("idle_data_err_count", err_cnt - e0, 3);

        chk_i("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
